// File: rtl/mem_ctrl.sv
// mem_ctrl: unified instruction/data memory controller for the multicycle MIPS CPU.
// Accepts one request at a time over a valid/ready port and answers with a
// single-cycle response pulse after WAIT_CYCLES extra latency cycles.
// Operations: LW, SW, SB (big-endian byte lanes) and atomic SWAP.
// Optional feature: define MEM_ALIGN_CHECK_EN to flag misaligned word accesses
// (LW/SW/SWAP with addr[1:0] != 0) through resp_err and suppress their effects.
module mem_ctrl #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 1,
    parameter int AW          = 10
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    localparam logic [1:0] OP_LW   = 2'b00;
    localparam logic [1:0] OP_SW   = 2'b01;
    localparam logic [1:0] OP_SB   = 2'b10;
    localparam logic [1:0] OP_SWAP = 2'b11;

    // Wait counter only has to reach WAIT_CYCLES-1; keep at least one bit.
    localparam int CW = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES);

    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [1:0]    r_op;
    logic [AW-1:0] r_idx;
    logic [1:0]    r_lane;
    logic [31:0]   r_wdata;
    logic [31:0]   r_rdata;
    logic          r_err;
    logic [31:0]   r_mem [DEPTH];

    logic          w_accept;
    logic [31:0]   w_old;
    logic [31:0]   w_merged;
    logic [31:0]   w_wword;
    logic          w_misalign;
    logic          w_write;
    logic          w_unused;

    // Address bits above the word index wrap away; they are deliberately dropped.
    assign w_unused = &{1'b0, req_addr[31:AW+2]};

    assign req_ready  = (r_state == S_IDLE) && !reset;
    assign w_accept   = req_valid && req_ready;
    assign resp_valid = (r_state == S_RESP);
    assign busy       = (r_state != S_IDLE);
    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;

`ifdef MEM_ALIGN_CHECK_EN
    assign w_misalign = (r_op != OP_SB) && (r_lane != 2'b00);
`else
    assign w_misalign = 1'b0;
`endif

    assign w_old = r_mem[r_idx];

    // Byte-store merge: replace only the addressed big-endian lane of the old word.
    always_comb begin
        // NOTE: default assignment first so every path drives w_merged and no latch is inferred.
        w_merged = w_old;
        case (r_lane)
            2'd0:    w_merged[31:24] = r_wdata[7:0];
            2'd1:    w_merged[23:16] = r_wdata[7:0];
            2'd2:    w_merged[15:8]  = r_wdata[7:0];
            default: w_merged[7:0]   = r_wdata[7:0];
        endcase
    end

    assign w_wword = (r_op == OP_SB) ? w_merged : r_wdata;
    // Writes happen only on the ACCESS exit edge; reset forces IDLE first, aborting them.
    assign w_write = (r_state == S_ACCESS) && !reset && !w_misalign && (r_op != OP_LW);

    // Request FSM: accept, optional wait states, array access, response pulse.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_op    <= OP_LW;
            r_idx   <= '0;
            r_lane  <= 2'b00;
            r_wdata <= 32'h0;
            r_rdata <= 32'h0;
            r_err   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op    <= req_op;
                        r_idx   <= req_addr[AW+1:2];
                        r_lane  <= req_addr[1:0];
                        r_wdata <= req_wdata;
                        r_cnt   <= '0;
                        r_state <= (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == CW'(WAIT_CYCLES - 1)) begin
                        r_cnt   <= '0;
                        r_state <= S_ACCESS;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_ACCESS: begin
                    r_err <= w_misalign;
                    if (!w_misalign && ((r_op == OP_LW) || (r_op == OP_SWAP)))
                        r_rdata <= w_old;
                    else
                        r_rdata <= 32'h0;
                    r_state <= S_RESP;
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Storage array write port; SWAP reads the old word and writes on the same edge.
    always_ff @(posedge clock) begin
        // NOTE: the array is intentionally not reset; its contents survive reset.
        if (w_write)
            r_mem[r_idx] <= w_wword;
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: directed scenarios plus randomized traffic,
// checked against a word-array reference model of the controller's behaviour.
module tb_mem_ctrl;

    localparam int DEPTH = 1024;
    localparam int W     = 1;

    localparam logic [1:0] LW   = 2'b00;
    localparam logic [1:0] SW   = 2'b01;
    localparam logic [1:0] SB   = 2'b10;
    localparam logic [1:0] SWAP = 2'b11;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'b00;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        busy;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] m_mem [DEPTH];
    logic [31:0] m_last = 32'h0;

    mem_ctrl #(.DEPTH(DEPTH), .WAIT_CYCLES(W), .AW(10)) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: apply one request to the word array, return expected response.
    task automatic model_apply(input logic [1:0] op, input logic [31:0] addr,
                               input logic [31:0] wd, output logic [31:0] rd,
                               output logic err);
        int idx;
        int sh;
        bit mis;
        idx = int'((addr >> 2) % 32'(DEPTH));
        sh  = 24 - 8 * int'(addr[1:0]);
`ifdef MEM_ALIGN_CHECK_EN
        mis = (op != SB) && (addr[1:0] != 2'b00);
`else
        mis = 1'b0;
`endif
        err = mis;
        rd  = 32'h0;
        if (!mis) begin
            case (op)
                LW:   rd = m_mem[idx];
                SW:   m_mem[idx] = wd;
                SB:   m_mem[idx] = (m_mem[idx] & ~(32'hFF << sh)) | ({24'h0, wd[7:0]} << sh);
                default: begin
                    rd = m_mem[idx];
                    m_mem[idx] = wd;
                end
            endcase
        end
    endtask

    // One complete transaction with protocol, latency and data comparisons.
    task automatic run_txn(input logic [1:0] op, input logic [31:0] addr,
                           input logic [31:0] wd, input string name);
        logic [31:0] erd;
        logic        eerr;
        int          lat;
        bit          got;
        model_apply(op, addr, wd, erd, eerr);
        @(negedge clock);
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL %s ready_idle: got %b want 1", name, req_ready);
        end
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wd;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        req_op    = 2'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
        got = 1'b0;
        lat = 0;
        while (!got && lat < 20) begin
            @(negedge clock);
            lat++;
            if (resp_valid === 1'b1) begin
                got = 1'b1;
            end else begin
                n_cmp++;
                if (req_ready !== 1'b0 || busy !== 1'b1) begin
                    n_bad++;
                    $display("FAIL %s pending: ready=%b busy=%b want 0/1 (cycle %0d)",
                             name, req_ready, busy, lat);
                end
            end
        end
        n_cmp++;
        if (!got) begin
            n_bad++;
            $display("FAIL %s timeout: no resp_valid within %0d cycles", name, lat);
        end else if (lat != W + 2) begin
            n_bad++;
            $display("FAIL %s latency: got %0d want %0d", name, lat, W + 2);
        end
        if (got) begin
            n_cmp++;
            if (resp_rdata !== erd || resp_err !== eerr || req_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL %s resp: rdata=%h err=%b ready=%b want %h/%b/0",
                         name, resp_rdata, resp_err, req_ready, erd, eerr);
            end
            m_last = erd;
        end
        @(negedge clock);
        n_cmp++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1 || resp_rdata !== m_last) begin
            n_bad++;
            $display("FAIL %s after_resp: valid=%b ready=%b rdata=%h want 0/1/%h",
                     name, resp_valid, req_ready, resp_rdata, m_last);
        end
    endtask

    task automatic test_reset();
        req_valid = 1'b1;
        req_op    = SW;
        req_addr  = 32'h20;
        req_wdata = 32'h11111111;
        repeat (3) @(negedge clock);
        n_cmp++;
        if (resp_valid !== 1'b0 || resp_rdata !== 32'h0 || resp_err !== 1'b0 ||
            busy !== 1'b0 || req_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_outputs: valid=%b rdata=%h err=%b busy=%b ready=%b want 0",
                     resp_valid, resp_rdata, resp_err, busy, req_ready);
        end
        req_valid = 1'b0;
        reset = 1'b0;
        @(negedge clock);
        n_cmp++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_release: ready=%b busy=%b want 1/0", req_ready, busy);
        end
    endtask

    task automatic test_word();
        run_txn(SW, 32'h20, 32'hDEADBEEF, "sw_20");
        run_txn(LW, 32'h20, 32'h0, "lw_20");
        n_cmp++;
        if (resp_rdata !== 32'hDEADBEEF) begin
            n_bad++;
            $display("FAIL word_value: got %h want deadbeef", resp_rdata);
        end
    endtask

    task automatic test_byte();
        run_txn(SB, 32'h21, 32'h55, "sb_21");
        run_txn(SB, 32'h23, 32'hAA, "sb_23");
        run_txn(LW, 32'h20, 32'h0, "lw_20_sb");
        n_cmp++;
        if (resp_rdata !== 32'hDE55BEAA) begin
            n_bad++;
            $display("FAIL byte_value: got %h want de55beaa", resp_rdata);
        end
    endtask

    task automatic test_swap();
        run_txn(SW, 32'h40, 32'h0000000F, "sw_40");
        run_txn(SWAP, 32'h40, 32'h12345678, "swap_40");
        n_cmp++;
        if (resp_rdata !== 32'h0000000F) begin
            n_bad++;
            $display("FAIL swap_old: got %h want 0000000f", resp_rdata);
        end
        run_txn(LW, 32'h40, 32'h0, "lw_40");
        n_cmp++;
        if (resp_rdata !== 32'h12345678) begin
            n_bad++;
            $display("FAIL swap_new: got %h want 12345678", resp_rdata);
        end
    endtask

    task automatic test_wrap();
        run_txn(SW, 32'h1000, 32'h1, "sw_1000");
        run_txn(LW, 32'h0, 32'h0, "lw_0");
        n_cmp++;
        if (resp_rdata !== 32'h1) begin
            n_bad++;
            $display("FAIL wrap_value: got %h want 00000001", resp_rdata);
        end
    endtask

    task automatic test_reset_abort();
        run_txn(SW, 32'h80, 32'h7, "sw_80");
        @(negedge clock);
        req_valid = 1'b1;
        req_op    = SW;
        req_addr  = 32'h80;
        req_wdata = 32'h9;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        #1;
        n_cmp++;
        if (resp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b0 ||
            resp_rdata !== 32'h0 || resp_err !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_in_reset: valid=%b busy=%b ready=%b rdata=%h err=%b want 0",
                     resp_valid, busy, req_ready, resp_rdata, resp_err);
        end
        @(negedge clock);
        reset  = 1'b0;
        m_last = 32'h0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            n_cmp++;
            if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
                n_bad++;
                $display("FAIL abort_after: valid=%b ready=%b want 0/1 (cycle %0d)",
                         resp_valid, req_ready, i);
            end
        end
        run_txn(LW, 32'h80, 32'h0, "lw_80");
        n_cmp++;
        if (resp_rdata !== 32'h7) begin
            n_bad++;
            $display("FAIL abort_mem: got %h want 00000007", resp_rdata);
        end
    endtask

    task automatic test_align();
        run_txn(LW, 32'h22, 32'h0, "lw_22");
        run_txn(SW, 32'h26, 32'hCAFEF00D, "sw_26");
        run_txn(SWAP, 32'h21, 32'h01020304, "swap_21");
        run_txn(LW, 32'h20, 32'h0, "lw_20_align");
        run_txn(LW, 32'h24, 32'h0, "lw_24_align");
    endtask

    task automatic test_back_to_back();
        int pulses[$];
        int n_cyc;
        logic [31:0] erd;
        logic        eerr;
        model_apply(LW, 32'h40, 32'h0, erd, eerr);
        n_cyc = 4 * (W + 3);
        @(negedge clock);
        req_valid = 1'b1;
        req_op    = LW;
        req_addr  = 32'h40;
        req_wdata = 32'h0;
        for (int c = 1; c <= n_cyc; c++) begin
            @(negedge clock);
            if (resp_valid === 1'b1) begin
                pulses.push_back(c);
                n_cmp++;
                if (resp_rdata !== erd) begin
                    n_bad++;
                    $display("FAIL b2b_data: got %h want %h", resp_rdata, erd);
                end
            end
        end
        req_valid = 1'b0;
        m_last = erd;
        n_cmp++;
        if (pulses.size() != 4) begin
            n_bad++;
            $display("FAIL b2b_count: got %0d pulses want 4", pulses.size());
        end
        for (int i = 1; i < pulses.size(); i++) begin
            n_cmp++;
            if (pulses[i] - pulses[i-1] != W + 3) begin
                n_bad++;
                $display("FAIL b2b_gap: got %0d want %0d", pulses[i] - pulses[i-1], W + 3);
            end
        end
        @(negedge clock);
    endtask

    task automatic test_random();
        logic [31:0] addr;
        logic [31:0] base;
        for (int i = 0; i < 16; i++)
            run_txn(SW, 32'h400 + 32'(i * 4), $urandom, "rnd_init");
        for (int n = 0; n < 40; n++) begin
            base = 32'h400 + 32'($urandom_range(0, 15) * 4);
            addr = ($urandom & 32'hFFFF_F000) | base | 32'($urandom_range(0, 3));
            run_txn(2'($urandom_range(0, 3)), addr, $urandom, "rnd");
        end
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_swap();
        test_wrap();
        test_reset_abort();
        test_align();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Unified instruction/data memory controller on the downstream side of the multicycle MIPS CPU.
- Replaces the CPU's internal flat Memory array with a request/response port.
- Supports word load, word store, byte store (sb) and atomic swap.
- Adds a configurable number of wait states, so CPU states 1 and 4 must stall until a response arrives.

Parameters:
- DEPTH, 1024: number of 32-bit words; power of two.
- WAIT_CYCLES, 1: extra latency cycles inserted before the array access; 0 is legal.
- AW, 10: word-index width; equals log2(DEPTH).

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  requester presents a request.
- req_ready  out  1  controller can accept a request this cycle.
- req_op  in  2  operation code:
  - 00 = LW (read word)
  - 01 = SW (write word)
  - 10 = SB (write byte)
  - 11 = SWAP (read old word, write new word)
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; for SB, the byte is in bits [7:0].
- resp_valid  out  1  one-cycle pulse: request completed.
- resp_rdata  out  32  read data; valid with resp_valid and held until the next response.
- resp_err  out  1  misalignment error flag; valid with resp_valid.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset is asynchronous and active-high. While reset is high:
  - state = IDLE, wait counter = 0;
  - resp_valid = 0, resp_rdata = 0, resp_err = 0, busy = 0;
  - req_ready = 0.
- Memory array contents are not reset and survive reset. After reset the contents are undefined until written or preloaded.
- FSM states and transitions:
  - IDLE:
    - req_ready = 1 when reset is low.
    - On an edge where req_valid && req_ready: latch op, addr and wdata.
    - Then go to WAIT if WAIT_CYCLES > 0, else ACCESS.
  - WAIT: count up from 0 to WAIT_CYCLES-1, then go to ACCESS. req_ready = 0.
  - ACCESS: perform the array operation on the exiting edge, load resp_rdata and resp_err, then go to RESP.
  - RESP: resp_valid = 1 for exactly this cycle, then go to IDLE.
- Latency: with acceptance at edge E, resp_valid is high during the cycle after edge E+WAIT_CYCLES+1.
  - Example: WAIT_CYCLES=1 gives response 3 cycles after the request is seen.
- Throughput: one request per WAIT_CYCLES+3 cycles.
- Word index = addr[AW+1:2]. Upper address bits are ignored, so addresses wrap modulo DEPTH*4 bytes.
- Operations (big-endian lanes: addr[1:0]=0 selects bits [31:24], 3 selects bits [7:0]):
  - LW: rdata = mem[idx].
  - SW: mem[idx] = wdata; rdata = 0.
  - SB: only the lane selected by addr[1:0] is replaced with wdata[7:0]; the other 3 bytes are unchanged; rdata = 0.
  - SWAP: rdata = old mem[idx] and mem[idx] = wdata, both on the same edge; atomic, no other request can interleave.
- req_valid while req_ready=0 is ignored; the requester must hold the request until it is accepted. Request inputs are sampled only on the accept edge.
- Reset mid-operation aborts the request:
  - A write whose ACCESS exit edge has not occurred is never performed.
  - No resp_valid is produced for an aborted request.
- resp_rdata and resp_err hold their values after RESP until the next ACCESS.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- When defined, for LW, SW or SWAP with addr[1:0] != 0:
  - memory is not modified;
  - resp_err = 1 and resp_rdata = 0;
  - timing is unchanged.
- SB is never flagged as an error.
- When not defined: addr[1:0] is ignored for word operations and resp_err is tied to 0.

Test Plan:
1. WAIT_CYCLES=1: SW addr 0x20 data 0xDEADBEEF, then LW 0x20.
   -> Each resp_valid is a single pulse 3 cycles after acceptance. LW rdata = 0xDEADBEEF. req_ready = 0 from the accept edge until after RESP.
2. SB sequence on addr 0x20 holding 0xDEADBEEF: SB 0x21 data 0x55, then SB 0x23 data 0xAA, then LW 0x20.
   -> LW rdata = 0xDE55BEAA.
3. SWAP 0x40 data 0x12345678 where mem holds 0x0000000F, then LW 0x40.
   -> SWAP rdata = 0x0000000F; LW rdata = 0x12345678.
4. Wrap-around, DEPTH=1024: SW addr 0x1000 data 0x1, then LW addr 0x0.
   -> LW rdata = 0x1.
5. Reset pulse during WAIT of SW 0x80 data 0x9 (mem held 0x7).
   -> No resp_valid is produced; req_ready = 1 after reset deasserts; LW 0x80 returns 0x7.
6. With MEM_ALIGN_CHECK_EN defined, LW 0x22.
   -> resp_err = 1, rdata = 0.
   Without the macro, the same LW returns mem[8] and resp_err = 0.
